ped_crossing_ctrl: RTL and testbench

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

---
 rtl/ped_crossing_ctrl.sv | 96 +++++++++
 tb/tb_ped_crossing_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK/FLASH sequencer slaved to the vehicle light.
module ped_crossing_ctrl #(
  parameter int WALK_TICKS  = 20,
  parameter int FLASH_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [5:0] countdown,
  output logic       req_pending,
  output logic       abort
);
  typedef enum logic [2:0] {DARK, IDLE, WAIT, WALK, FLASH} state_t;
  state_t state_q, state_d;
  logic [1:0] light_q;
  logic [5:0] cnt_q, cnt_d, cd_q, cd_d;
  logic req_q, req_d, walk_q, walk_d, dw_q, dw_d, abort_q, abort_d;
  logic red_entry, red_exit;
  always_comb begin
    red_entry = light == 2'b01 && light_q != 2'b01;
    red_exit  = light_q == 2'b01 && light[1];
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    abort_d = 1'b0;
    if (light == 2'b00) begin
      state_d = DARK;
      cnt_d = '0;
      req_d = 1'b0;
    end else begin
      case (state_q)
        DARK: state_d = IDLE;
        IDLE: if (ped_btn) begin
          state_d = red_entry ? WALK : WAIT;
          cnt_d = red_entry ? 6'(WALK_TICKS) : '0;
          req_d = !red_entry;
        end
        WAIT: if (red_entry) begin
          state_d = WALK;
          cnt_d = 6'(WALK_TICKS);
          req_d = 1'b0;
        end
        WALK, FLASH: begin
          req_d = req_q | ped_btn;
          if (red_exit) begin
            state_d = req_d ? WAIT : IDLE;
            cnt_d = '0;
            abort_d = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q == 6'd0 ? 6'd0 : cnt_q - 6'd1;
            if (cnt_q <= 6'd1) begin
              state_d = state_q == WALK ? FLASH : (req_d ? WAIT : IDLE);
              cnt_d = state_q == WALK ? 6'(FLASH_TICKS) : 6'd0;
            end
          end
        end
        default: state_d = DARK;
      endcase
    end
    // outputs are computed from the next state so they register together with it
    walk_d = state_d == WALK;
    dw_d = (state_d == IDLE || state_d == WAIT) ? 1'b1 :
           state_d == FLASH ? (state_q != FLASH ? 1'b1 : dw_q ^ tick) : 1'b0;
    cd_d = state_d == FLASH ? cnt_d : 6'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DARK;
      light_q <= 2'b00;
      cnt_q <= '0;
      cd_q <= '0;
      req_q <= 1'b0;
      walk_q <= 1'b0;
      dw_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light;
      cnt_q <= cnt_d;
      cd_q <= cd_d;
      req_q <= req_d;
      walk_q <= walk_d;
      dw_q <= dw_d;
      abort_q <= abort_d;
    end
  end
  assign walk = walk_q;
  assign dont_walk = dw_q;
  assign countdown = cd_q;
  assign req_pending = req_q;
  assign abort = abort_q;
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_ped_crossing_ctrl;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, ped_btn = 1'b0;
  logic [1:0] light = 2'b00;
  logic walk, dont_walk, req_pending, abort;
  logic [5:0] countdown;
  logic [9:0] exp_q[$];
  int checks = 0, errors = 0, step = 0;

  ped_crossing_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .light(light), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .countdown(countdown),
    .req_pending(req_pending), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [9:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {walk, dont_walk, countdown, req_pending, abort};
      checks++;
      step++;
      if (g !== e) begin
        errors++;
        $display("FAIL step%0d: got w=%b dw=%b cd=%0d rq=%b ab=%b, expected w=%b dw=%b cd=%0d rq=%b ab=%b",
                 step, g[9], g[8], g[7:2], g[1], g[0], e[9], e[8], e[7:2], e[1], e[0]);
      end
    end
  end

  task automatic cyc(input logic [1:0] l, input logic b, t, w, dw,
                     input logic [5:0] cd, input logic rq, ab);
    light = l;
    ped_btn = b;
    tick = t;
    exp_q.push_back({w, dw, cd, rq, ab});
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'b11, 1, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    // basic cycle
    cyc(2'b11, 0, 0, 0, 1, 0, 0, 0);
    cyc(2'b11, 1, 0, 0, 1, 0, 1, 0);
    cyc(2'b11, 0, 1, 0, 1, 0, 1, 0);
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) cyc(2'b01, 0, 1, 1, 0, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 6'd10, 0, 0);
    for (int i = 1; i < 10; i++) cyc(2'b01, 0, 1, 0, ~i[0], 6'(10 - i), 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 0, 0);
    // request while already red waits for the next red entry
    cyc(2'b01, 1, 0, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 0, 0, 1, 0, 1, 0);
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 0, 1, 0, 0, 0, 0);
    // abort after 5 WALK ticks
    for (int i = 0; i < 5; i++) cyc(2'b01, 0, 1, 1, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 1, 0, 0, 1);
    cyc(2'b11, 0, 0, 0, 1, 0, 0, 0);
    // button coinciding with red entry goes straight to WALK
    cyc(2'b01, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) cyc(2'b01, 0, 1, 1, 0, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 6'd10, 0, 0);
    cyc(2'b01, 0, 1, 0, 0, 6'd9, 0, 0);
    // re-request during FLASH
    cyc(2'b01, 1, 0, 0, 0, 6'd9, 1, 0);
    for (int i = 2; i < 10; i++) cyc(2'b01, 0, 1, 0, ~i[0], 6'(10 - i), 1, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 0, 0, 1, 0, 1, 0);
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 0);
    cyc(2'b01, 0, 0, 1, 0, 0, 0, 0);
    // light off during FLASH
    for (int i = 1; i < 20; i++) cyc(2'b01, 0, 1, 1, 0, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 6'd10, 0, 0);
    cyc(2'b01, 1, 1, 0, 0, 6'd9, 1, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'b00, 0, 1, 0, 0, 0, 0, 0);
    // reset mid-WALK
    cyc(2'b01, 0, 0, 0, 1, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 1, 0, 0, 0);
    cyc(2'b01, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 0, 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2'b01, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(2'b01, 0, 0, 0, 1, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 0, 0);
    cyc(2'b01, 0, 1, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
